// File: rtl/letter_display_ctrl.sv
// Key-driven letter loader for a row of seven-segment digits, with optional
// periodic rotation of the stored letters toward the most significant digit.
module letter_display_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int DEBOUNCE_CYC = 16,
   parameter int SCROLL_DIV   = 25000000
) (
   input  logic                      CLOCK_50,
   input  logic                      RESET_N,
   input  logic [NUM_DIGITS-1:0]     KEY,
   input  logic [9:0]                SW,
   input  logic                      SCROLL_EN,
   output logic [3:0]                Code,
   output logic [7*NUM_DIGITS-1:0]   HEX
);

   localparam int CW = $clog2(DEBOUNCE_CYC);
   localparam int TW = $clog2(SCROLL_DIV);
   localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYC - 1);
   localparam logic [TW-1:0] TMR_LAST = TW'(SCROLL_DIV - 1);

   logic [NUM_DIGITS-1:0] key_meta;
   logic [NUM_DIGITS-1:0] key_sync;
   logic [NUM_DIGITS-1:0] key_level;
   logic [NUM_DIGITS-1:0] key_level_d;
   logic [NUM_DIGITS-1:0] press;
   logic [CW-1:0]         db_cnt [NUM_DIGITS];
   logic [TW-1:0]         tmr;
   logic                  step;
   logic [3:0]            dig_code [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] dig_valid;

   function automatic logic [6:0] glyph(input logic [3:0] c);
      logic [6:0] g;
      case (c)
         4'd0:    g = 7'b0001000;
         4'd1:    g = 7'b0001100;
         4'd2:    g = 7'b0000110;
         4'd3:    g = 7'b1111001;
         4'd4:    g = 7'b0001001;
         4'd5:    g = 7'b1000111;
         4'd6:    g = 7'b1000110;
         4'd7:    g = 7'b1000001;
         default: g = 7'b0111111;
      endcase
      return g;
   endfunction

   assign Code = SW[8] ? SW[7:4] : SW[3:0];
   assign step = SCROLL_EN && (tmr == TMR_LAST);

   // Keys: two-flop sync, then a level that only follows after DEBOUNCE_CYC
   // consecutive disagreeing samples; press is a registered falling edge.
   always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) begin
         key_meta    <= '1;
         key_sync    <= '1;
         key_level   <= '1;
         key_level_d <= '1;
         press       <= '0;
         for (int i = 0; i < NUM_DIGITS; i++) db_cnt[i] <= '0;
      end else begin
         key_meta    <= KEY;
         key_sync    <= key_meta;
         key_level_d <= key_level;
         press       <= key_level_d & ~key_level;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (key_sync[i] != key_level[i]) begin
               if (db_cnt[i] == DB_LAST) begin
                  key_level[i] <= key_sync[i];
                  db_cnt[i]    <= '0;
               end else begin
                  db_cnt[i] <= db_cnt[i] + 1'b1;
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!RESET_N || !SCROLL_EN) begin
         tmr <= '0;
      end else if (tmr == TMR_LAST) begin
         tmr <= '0;
      end else begin
         tmr <= tmr + 1'b1;
      end
   end

   // A load on the step cycle wins for that digit; the value it would have
   // received from its neighbour is simply lost.
   always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) begin
         dig_valid <= '0;
         for (int i = 0; i < NUM_DIGITS; i++) dig_code[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (press[i] || SW[9]) begin
               dig_code[i]  <= Code;
               dig_valid[i] <= 1'b1;
            end else if (step) begin
               dig_code[i]  <= dig_code[(i + NUM_DIGITS - 1) % NUM_DIGITS];
               dig_valid[i] <= dig_valid[(i + NUM_DIGITS - 1) % NUM_DIGITS];
            end
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) begin
         HEX <= '1;
      end else begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            HEX[7*i +: 7] <= dig_valid[i] ? glyph(dig_code[i]) : 7'b1111111;
         end
      end
   end

endmodule

// File: tb/tb_letter_display_ctrl.sv
// Scoreboard bench for letter_display_ctrl: stimulus pushes expected displays
// with a cycle window, a monitor pops one entry per observed HEX change.
module tb_letter_display_ctrl;

   localparam int ND = 4;
   localparam int DB = 16;
   localparam int SD = 4;
   localparam int HW = 7 * ND;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [ND-1:0] key = '1;
   logic [9:0]    sw = '0;
   logic          scroll_en = 1'b0;
   logic [3:0]    code;
   logic [HW-1:0] hex;

   letter_display_ctrl #(
      .NUM_DIGITS  (ND),
      .DEBOUNCE_CYC(DB),
      .SCROLL_DIV  (SD)
   ) dut (
      .CLOCK_50 (clk),
      .RESET_N  (rst_n),
      .KEY      (key),
      .SW       (sw),
      .SCROLL_EN(scroll_en),
      .Code     (code),
      .HEX      (hex)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [HW-1:0] hex;
      int            lo;
      int            hi;
   } exp_t;

   exp_t          sbq[$];
   int            total = 0;
   int            bad = 0;
   bit            armed = 0;
   logic [HW-1:0] prev_hex;
   logic [HW-1:0] last_exp;
   logic [3:0]    m_code [ND];
   logic          m_valid [ND];
   logic [6:0]    glyph_tab [16] = '{7'b0001000, 7'b0001100, 7'b0000110, 7'b1111001,
                                     7'b0001001, 7'b1000111, 7'b1000110, 7'b1000001,
                                     7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111,
                                     7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

   function automatic logic [HW-1:0] model_disp();
      logic [HW-1:0] d;
      for (int i = 0; i < ND; i++) d[7*i +: 7] = m_valid[i] ? glyph_tab[m_code[i]] : 7'b1111111;
      return d;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < ND; i++) begin
         m_code[i]  = 4'd0;
         m_valid[i] = 1'b0;
      end
   endtask

   task automatic model_rotate();
      logic [3:0] tc [ND];
      logic       tv [ND];
      for (int i = 0; i < ND; i++) begin
         tc[i] = m_code[i];
         tv[i] = m_valid[i];
      end
      for (int i = 0; i < ND; i++) begin
         m_code[i]  = tc[(i + ND - 1) % ND];
         m_valid[i] = tv[(i + ND - 1) % ND];
      end
   endtask

   // Only a display that differs from the previous one is observable as a change.
   task automatic expect_at(input int lo, input int hi);
      logic [HW-1:0] d;
      d = model_disp();
      if (d !== last_exp) begin
         sbq.push_back('{d, lo, hi});
         last_exp = d;
      end
   endtask

   task automatic check_code(input logic [3:0] exp_c);
      total++;
      if (code !== exp_c) begin
         bad++;
         $display("FAIL code cyc=%0d got=%0d want=%0d", cyc, code, exp_c);
      end
   endtask

   task automatic set_sw(input logic [3:0] c4, input bit sel, input bit load);
      sw[8] = sel;
      sw[9] = load;
      if (sel) begin
         sw[7:4] = c4;
         sw[3:0] = 4'($urandom);
      end else begin
         sw[3:0] = c4;
         sw[7:4] = 4'($urandom);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (armed && hex !== prev_hex) begin
         if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_change cyc=%0d got=%h", cyc, hex);
         end else begin
            e = sbq.pop_front();
            total++;
            if (hex !== e.hex) begin
               bad++;
               $display("FAIL display_value cyc=%0d got=%h want=%h", cyc, hex, e.hex);
            end
            total++;
            if (cyc < e.lo || cyc > e.hi) begin
               bad++;
               $display("FAIL display_timing got_cyc=%0d want=%0d..%0d", cyc, e.lo, e.hi);
            end
         end
      end
      prev_hex = hex;
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      scroll_en = 1'b0;
      key = '1;
      model_clear();
      expect_at(cyc + 1, cyc + 1);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic do_load_all(input logic [3:0] c4, input bit sel);
      int c;
      @(negedge clk);
      c = cyc;
      set_sw(c4, sel, 1'b1);
      #1 check_code(c4);
      for (int i = 0; i < ND; i++) begin
         m_code[i]  = c4;
         m_valid[i] = 1'b1;
      end
      expect_at(c + 2, c + 2);
      @(negedge clk);
      sw[9] = 1'b0;
   endtask

   task automatic do_press(input int d, input logic [3:0] c4, input bit sel,
                           input bit bounce, input int hold);
      int c;
      @(negedge clk);
      set_sw(c4, sel, 1'b0);
      #1 check_code(c4);
      @(negedge clk);
      if (bounce) begin
         for (int t = 0; t < 5; t++) begin
            key[d] = ~key[d];
            if (t < 4) repeat (3) @(negedge clk);
         end
      end else begin
         key[d] = 1'b0;
      end
      c = cyc;
      m_code[d]  = c4;
      m_valid[d] = 1'b1;
      expect_at(c + 20, c + 22);
      repeat (hold) @(negedge clk);
      key[d] = 1'b1;
      repeat (DB + 8) @(negedge clk);
   endtask

   task automatic do_scroll(input int k);
      int c;
      @(negedge clk);
      c = cyc;
      scroll_en = 1'b1;
      for (int j = 1; j <= k; j++) begin
         model_rotate();
         expect_at(c + j * SD + 1, c + j * SD + 1);
      end
      repeat (k * SD) @(negedge clk);
      scroll_en = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog cyc=%0d pending=%0d", cyc, sbq.size());
      $fatal(1, "bench timed out");
   end

   initial begin
      int c;
      int r;
      model_clear();
      repeat (3) @(negedge clk);
      total++;
      if (hex !== '1) begin
         bad++;
         $display("FAIL reset_hex got=%h want=%h", hex, {HW{1'b1}});
      end
      check_code(4'd0);
      rst_n = 1'b1;
      last_exp = '1;
      armed = 1'b1;

      do_press(2, 4'd1, 1'b0, 1'b0, 100);
      do_press(0, 4'd6, 1'b0, 1'b1, 40);
      do_load_all(4'd2, 1'b1);

      do_press(0, 4'd0, 1'b0, 1'b0, 30);
      do_press(1, 4'd1, 1'b1, 1'b0, 30);
      do_press(2, 4'd2, 1'b0, 1'b0, 30);
      do_press(3, 4'd4, 1'b1, 1'b0, 30);
      do_scroll(4);

      // Key press captured on the same edge as the fifth scroll step.
      @(negedge clk);
      c = cyc;
      set_sw(4'd9, 1'b0, 1'b0);
      key[1] = 1'b0;
      scroll_en = 1'b1;
      for (int j = 1; j <= 5; j++) begin
         model_rotate();
         if (j == 5) begin
            m_code[1]  = 4'd9;
            m_valid[1] = 1'b1;
         end
         expect_at(c + 4 * j + 1, c + 4 * j + 1);
      end
      repeat (22) @(negedge clk);

      // Reset two cycles into a scroll period; scrolling stays enabled.
      r = cyc;
      rst_n = 1'b0;
      key[1] = 1'b1;
      set_sw(4'd0, 1'b0, 1'b0);
      model_clear();
      expect_at(r + 1, r + 1);
      @(negedge clk);
      rst_n = 1'b1;
      key[0] = 1'b0;
      model_rotate();
      m_code[0]  = 4'd0;
      m_valid[0] = 1'b1;
      expect_at(r + 22, r + 22);
      model_rotate();
      expect_at(r + 26, r + 26);
      repeat (24) @(negedge clk);
      scroll_en = 1'b0;
      repeat (20) @(negedge clk);
      key[0] = 1'b1;
      repeat (DB + 8) @(negedge clk);

      for (int n = 0; n < 30; n++) begin
         int op;
         op = int'($urandom_range(0, 9));
         if (op <= 2) do_load_all(4'($urandom), 1'($urandom));
         else if (op <= 6) do_press(int'($urandom_range(0, ND - 1)), 4'($urandom),
                                    1'($urandom), 1'($urandom), 40);
         else if (op <= 8) do_scroll(int'($urandom_range(1, 4)));
         else do_reset();
      end

      repeat (30) @(negedge clk);
      total++;
      if (sbq.size() != 0) begin
         bad++;
         $display("FAIL pending_expect got=%0d want=0", sbq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
